// File: rtl/regbus_pkg.sv
// regbus_pkg: shared definitions for the register-bus arbiter.
//   ADDR_W / DATA_W  : register address and data widths
//   ENTRY_W          : debug FIFO entry width ({addr, wdata})
//   FIFO_DEPTH_DEF   : default debug write FIFO depth
//   STARVE_MAX_DEF   : default host grants allowed while debug writes wait
//   state_e          : access sequencer states
package regbus_pkg;

    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned ENTRY_W        = ADDR_W + DATA_W;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/regbus_fifo.sv
// regbus_fifo: synchronous FIFO holding queued debug register writes.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/din_i : write an entry (dropped when full unless a pop frees a slot)
//   pop_i        : consume the head entry (ignored when empty)
//   dout_o       : head entry
//   full_o       : registered full flag
//   empty_o      : registered empty flag
//   overflow_o   : push_i this cycle was dropped
module regbus_fifo
    import regbus_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when the head is being consumed.
    always_comb begin
        do_pop  = pop_i && !empty_q;
        do_push = push_i && (!full_q || do_pop);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign overflow_o = push_i && !do_push;
    assign dout_o     = mem_q[rptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            // Power-of-two depth: pointers wrap naturally at PTR_W bits.
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: shares the register-file access port between the host
// bus and the SPI debug write path.
//   clk25, reset         : clock, asynchronous active-high reset
//   host_req/wr/addr/wdata: one-cycle host request, held in a one-entry slot
//   host_busy            : request pending or being issued
//   host_ack/host_rdata  : completion pulse and read data (CAPTURE cycle)
//   host_err             : sticky, request arrived while busy
//   dbg_wr/addr/wdata    : debug write pushed into the FIFO
//   dbg_ovf              : sticky, debug write dropped on a full FIFO
//   reg_strobe/wr/addr/wdata : registered access to the register file
//   reg_rdata            : register read data, valid the cycle after the strobe
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_busy,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    input  logic              dbg_wr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ovf,
    output logic              reg_strobe,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    state_e              state_q;
    logic                cur_host_q;
    logic                cur_rd_q;
    logic                reg_strobe_q, reg_wr_q;
    logic [ADDR_W-1:0]   reg_addr_q;
    logic [DATA_W-1:0]   reg_wdata_q;

    logic                pend_vld_q, pend_wr_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic [DATA_W-1:0]   pend_wdata_q;

    logic [STARVE_W-1:0] starve_q;
    logic                host_err_q, dbg_ovf_q;

    logic [ENTRY_W-1:0]  fifo_dout;
    logic                fifo_full, fifo_empty, fifo_ovf;

    logic                host_accept, host_want, decide, starved;
    logic                grant_host, grant_dbg;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    regbus_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk25),
        .rst_i      (reset),
        .push_i     (dbg_wr),
        .din_i      ({dbg_addr, dbg_wdata}),
        .pop_i      (grant_dbg),
        .dout_o     (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    // The host transfer counts as busy until its ACK cycle, so a host that
    // re-requests on the ACK cycle keeps the port at one access per 2 cycles.
    assign host_busy = pend_vld_q || (state_q == ST_ISSUE && cur_host_q);

    always_comb begin
        host_accept = host_req && !host_busy;
        host_want   = pend_vld_q || host_accept;
        sel_wr      = pend_vld_q ? pend_wr_q    : host_wr;
        sel_addr    = pend_vld_q ? pend_addr_q  : host_addr;
        sel_wdata   = pend_vld_q ? pend_wdata_q : host_wdata;
        decide      = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);
        starved     = (starve_q == STARVE_W'(STARVE_MAX)) && !fifo_empty;
        grant_host  = decide && host_want && !starved;
        grant_dbg   = decide && !fifo_empty && !grant_host;
    end

    assign host_ack   = (state_q == ST_CAPTURE) && cur_host_q;
    assign host_rdata = (host_ack && cur_rd_q) ? reg_rdata : '0;
    assign host_err   = host_err_q;
    assign dbg_ovf    = dbg_ovf_q;
    assign reg_strobe = reg_strobe_q;
    assign reg_wr     = reg_wr_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_host_q   <= 1'b0;
            cur_rd_q     <= 1'b0;
            reg_strobe_q <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
        end else begin
            reg_strobe_q <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            unique case (state_q)
                ST_IDLE, ST_CAPTURE: begin
                    if (grant_host) begin
                        state_q      <= ST_ISSUE;
                        cur_host_q   <= 1'b1;
                        cur_rd_q     <= !sel_wr;
                        reg_strobe_q <= 1'b1;
                        reg_wr_q     <= sel_wr;
                        reg_addr_q   <= sel_addr;
                        reg_wdata_q  <= sel_wdata;
                    end else if (grant_dbg) begin
                        state_q      <= ST_ISSUE;
                        cur_host_q   <= 1'b0;
                        cur_rd_q     <= 1'b0;
                        reg_strobe_q <= 1'b1;
                        reg_wr_q     <= 1'b1;
                        reg_addr_q   <= fifo_dout[ENTRY_W-1:DATA_W];
                        reg_wdata_q  <= fifo_dout[DATA_W-1:0];
                    end else begin
                        state_q    <= ST_IDLE;
                        cur_host_q <= 1'b0;
                        cur_rd_q   <= 1'b0;
                    end
                end
                ST_ISSUE: state_q <= ST_CAPTURE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // A request granted in its own arrival cycle bypasses the pending slot.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            pend_vld_q   <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
        end else if (grant_host) begin
            pend_vld_q <= 1'b0;
        end else if (host_accept) begin
            pend_vld_q   <= 1'b1;
            pend_wr_q    <= host_wr;
            pend_addr_q  <= host_addr;
            pend_wdata_q <= host_wdata;
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (fifo_empty || grant_dbg) begin
            starve_q <= '0;
        end else if (grant_host && starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            host_err_q <= 1'b0;
            dbg_ovf_q  <= 1'b0;
        end else begin
            if (host_req && host_busy) host_err_q <= 1'b1;
            if (fifo_ovf)              dbg_ovf_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: directed bench for regbus_arbiter with an access
// scoreboard (expected register accesses and host acks in grant order).
module tb_regbus_arbiter;

    logic       clk25 = 1'b0;
    logic       reset = 1'b1;
    logic       host_req = 1'b0, host_wr = 1'b0;
    logic [4:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_busy, host_ack, host_err;
    logic [7:0] host_rdata;
    logic       dbg_wr = 1'b0;
    logic [4:0] dbg_addr = '0;
    logic [7:0] dbg_wdata = '0;
    logic       dbg_ovf, reg_strobe, reg_wr;
    logic [4:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_acc [$];   // {wr, addr, wdata}
    int          exp_ack [$];   // expected host_rdata, -1 for writes

    regbus_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk25      (clk25),
        .reset      (reset),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_busy  (host_busy),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ovf    (dbg_ovf),
        .reg_strobe (reg_strobe),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    always #5 clk25 = ~clk25;

    // Register file stand-in: fixed read pattern, data valid the cycle after the strobe.
    function automatic logic [7:0] rf_val(input logic [4:0] a);
        return (a == 5'h03) ? 8'hA5 : {3'b101, a};
    endfunction

    always @(posedge clk25) begin
        if (reg_strobe) reg_rdata <= rf_val(reg_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic hr, input logic hw, input logic [4:0] ha, input logic [7:0] hd,
                       input logic dw, input logic [4:0] da, input logic [7:0] dd);
        @(posedge clk25); #1;
        host_req = hr; host_wr = hw; host_addr = ha; host_wdata = hd;
        dbg_wr = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00);
    endtask

    task automatic mid();
        @(negedge clk25);
    endtask

    // Scoreboard: every strobe and host ack must match the next expected entry.
    always @(negedge clk25) begin : mon
        logic [13:0] ea;
        int          ek;
        if (!reset) begin
            if (reg_strobe) begin
                if (exp_acc.size() == 0) chk("acc_unexpected", 32'(reg_strobe), 32'd0);
                else begin
                    ea = exp_acc.pop_front();
                    chk("acc", 32'({reg_wr, reg_addr, reg_wdata}), 32'(ea));
                end
            end
            if (host_ack) begin
                if (exp_ack.size() == 0) chk("ack_unexpected", 32'(host_ack), 32'd0);
                else begin
                    ek = exp_ack.pop_front();
                    if (ek >= 0) chk("ack_rdata", 32'(host_rdata), ek);
                end
            end
        end
    end

    initial begin
        // Reset state
        idle(); idle(); mid();
        chk("rst_busy", 32'(host_busy), 0);
        chk("rst_ack", 32'(host_ack), 0);
        chk("rst_rdata", 32'(host_rdata), 0);
        chk("rst_strobe", 32'(reg_strobe), 0);
        chk("rst_regbus", 32'({reg_wr, reg_addr, reg_wdata}), 0);
        chk("rst_flags", 32'({host_err, dbg_ovf}), 0);
        idle(); reset = 1'b0;

        // Host read of 0x03: strobe at N+1, ack with 0xA5 at N+2
        cyc(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 5'h00, 8'h00);
        exp_acc.push_back({1'b0, 5'h03, 8'h00}); exp_ack.push_back(32'hA5);
        mid(); chk("A_busy_n", 32'(host_busy), 0);
        idle(); mid();
        chk("A_strobe", 32'(reg_strobe), 1);
        chk("A_wr", 32'(reg_wr), 0);
        chk("A_addr", 32'(reg_addr), 32'h03);
        chk("A_ack_early", 32'(host_ack), 0);
        chk("A_busy", 32'(host_busy), 1);
        idle(); mid();
        chk("A_ack", 32'(host_ack), 1);
        chk("A_rdata", 32'(host_rdata), 32'hA5);
        chk("A_strobe_off", 32'(reg_strobe), 0);
        idle(); mid();
        chk("A_ack_pulse", 32'(host_ack), 0);
        chk("A_idle_busy", 32'(host_busy), 0);
        chk("A_err", 32'(host_err), 0);

        // Same-cycle host write and debug write: host first, debug 2 cycles later
        cyc(1'b1, 1'b1, 5'h00, 8'h11, 1'b1, 5'h1F, 8'h22);
        exp_acc.push_back({1'b1, 5'h00, 8'h11}); exp_acc.push_back({1'b1, 5'h1F, 8'h22});
        exp_ack.push_back(-1);
        idle(); mid();
        chk("B_h_strobe", 32'(reg_strobe), 1);
        chk("B_h_addr", 32'(reg_addr), 32'h00);
        idle(); mid();
        chk("B_ack", 32'(host_ack), 1);
        chk("B_gap", 32'(reg_strobe), 0);
        idle(); mid();
        chk("B_d_strobe", 32'(reg_strobe), 1);
        chk("B_d_acc", 32'({reg_wr, reg_addr, reg_wdata}), 32'({1'b1, 5'h1F, 8'h22}));
        idle(); mid();
        chk("B_d_noack", 32'(host_ack), 0);
        idle();

        // Debug write alone in IDLE: no bypass, strobe two cycles later
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h07, 8'h99);
        exp_acc.push_back({1'b1, 5'h07, 8'h99});
        idle(); mid();
        chk("H_nobypass", 32'(reg_strobe), 0);
        idle(); mid();
        chk("H_strobe", 32'(reg_strobe), 1);
        idle(); idle();

        // Second host_req during the transfer: error flagged, first completes unchanged
        cyc(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 5'h00, 8'h00);
        exp_acc.push_back({1'b0, 5'h03, 8'h00}); exp_ack.push_back(32'hA5);
        cyc(1'b1, 1'b1, 5'h05, 8'h77, 1'b0, 5'h00, 8'h00); mid();
        chk("C_busy", 32'(host_busy), 1);
        chk("C_err_pre", 32'(host_err), 0);
        idle(); mid();
        chk("C_err", 32'(host_err), 1);
        chk("C_ack", 32'(host_ack), 1);
        chk("C_rdata", 32'(host_rdata), 32'hA5);
        idle(); mid();
        chk("C_no_second", 32'(reg_strobe), 0);
        chk("C_busy_clr", 32'(host_busy), 0);
        idle();

        // Starvation: host every 2 cycles, one debug entry pushed with host #0.
        // Host #0 is granted while the FIFO is still empty, so #1..#8 fill the
        // counter; at #9 debug wins and #9 is held pending until after it.
        for (int i = 0; i < 9; i++) exp_acc.push_back({1'b1, 5'(8 + i), 8'(8'hD0 + i)});
        exp_acc.push_back({1'b1, 5'h1E, 8'h5C});
        exp_acc.push_back({1'b1, 5'h11, 8'hD9});
        for (int i = 0; i < 10; i++) exp_ack.push_back(-1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 5'(8 + i), 8'(8'hD0 + i), (i == 0), 5'h1E, 8'h5C); mid();
            idle(); mid();
        end
        chk("D_dbg_strobe", 32'(reg_strobe), 1);
        chk("D_dbg_addr", 32'(reg_addr), 32'h1E);
        chk("D_pending", 32'(host_busy), 1);
        idle(); mid();
        chk("D_dbg_noack", 32'(host_ack), 0);
        idle(); mid();
        chk("D_resume_addr", 32'(reg_addr), 32'h11);
        idle(); mid();
        chk("D_resume_ack", 32'(host_ack), 1);
        idle(); idle();

        // Full FIFO with simultaneous push and pop: accepted, no overflow
        exp_acc.push_back({1'b1, 5'h02, 8'hE0}); exp_acc.push_back({1'b1, 5'h02, 8'hE1});
        exp_acc.push_back({1'b1, 5'h02, 8'hE2});
        for (int j = 0; j < 5; j++) exp_acc.push_back({1'b1, 5'(5'h14 + j), 8'(8'h40 + j)});
        for (int j = 0; j < 3; j++) exp_ack.push_back(-1);
        cyc(1'b1, 1'b1, 5'h02, 8'hE0, 1'b1, 5'h14, 8'h40);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h15, 8'h41);
        cyc(1'b1, 1'b1, 5'h02, 8'hE1, 1'b1, 5'h16, 8'h42);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h17, 8'h43);
        cyc(1'b1, 1'b1, 5'h02, 8'hE2, 1'b0, 5'h00, 8'h00);
        idle();
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h18, 8'h44);
        for (int j = 0; j < 12; j++) idle();
        mid();
        chk("F_no_ovf", 32'(dbg_ovf), 0);
        chk("F_drained", exp_acc.size(), 0);

        // Five debug writes behind host traffic: fifth dropped, four drain in order
        exp_acc.push_back({1'b1, 5'h04, 8'hF0}); exp_acc.push_back({1'b1, 5'h04, 8'hF1});
        exp_acc.push_back({1'b1, 5'h04, 8'hF2});
        for (int j = 0; j < 4; j++) exp_acc.push_back({1'b1, 5'(5'h19 + j), 8'(8'h50 + j)});
        for (int j = 0; j < 3; j++) exp_ack.push_back(-1);
        cyc(1'b1, 1'b1, 5'h04, 8'hF0, 1'b1, 5'h19, 8'h50);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1A, 8'h51);
        cyc(1'b1, 1'b1, 5'h04, 8'hF1, 1'b1, 5'h1B, 8'h52);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1C, 8'h53);
        cyc(1'b1, 1'b1, 5'h04, 8'hF2, 1'b1, 5'h1D, 8'h54); mid();
        chk("E_ovf_pre", 32'(dbg_ovf), 0);
        idle(); mid();
        chk("E_ovf", 32'(dbg_ovf), 1);
        for (int j = 0; j < 10; j++) idle();
        mid();
        chk("E_drained", exp_acc.size(), 0);
        chk("E_err_sticky", 32'(host_err), 1);
        chk("E_ovf_sticky", 32'(dbg_ovf), 1);

        // Reset in CAPTURE: outputs clear at once, no ack, queued debug writes lost
        exp_acc.push_back({1'b0, 5'h03, 8'h00});
        cyc(1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 5'h0C, 8'h66);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h0D, 8'h67); mid();
        chk("G_strobe", 32'(reg_strobe), 1);
        idle(); reset = 1'b1; mid();
        chk("G_ack", 32'(host_ack), 0);
        chk("G_rdata", 32'(host_rdata), 0);
        chk("G_strobe_rst", 32'(reg_strobe), 0);
        chk("G_regbus", 32'({reg_wr, reg_addr, reg_wdata}), 0);
        chk("G_busy", 32'(host_busy), 0);
        chk("G_flags", 32'({host_err, dbg_ovf}), 0);
        idle(); reset = 1'b0;
        for (int j = 0; j < 8; j++) idle();
        mid();
        chk("G_no_access", exp_acc.size(), 0);
        chk("G_no_ack", exp_ack.size(), 0);
        chk("G_flags_after", 32'({host_err, dbg_ovf}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
